// File: rtl/ifu_fetch.sv
// Instruction-fetch unit: owns the fetch PC, runs a single-outstanding imem
// request, and loads the IF/ID register with flush (redirect) and stall support.
module ifu_fetch #(
  parameter logic [29:0] RESET_PC = 30'h0000_0C00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] npc,
  input  logic        redirect,
  input  logic        stall,
  output logic        imem_req,
  output logic [29:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_id_valid,
  output logic [29:0] if_id_pc,
  output logic [31:0] if_id_ins
);

  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HOLD} state_t;

  state_t      state_q;
  logic [29:0] fpc_q;
  logic        drop_q;
  logic [31:0] hb_ins_q;
  logic        v_q;
  logic [29:0] pc_q;
  logic [31:0] ins_q;

  logic        ld_wait, ld_hold;
  logic [31:0] ld_ins;

  // A response is only usable when it belongs to the current fpc (no drop,
  // no redirect this cycle) and decode can accept it (no stall).
  assign ld_wait = (state_q == S_WAIT) && imem_rvalid && !drop_q && !redirect && !stall;
  assign ld_hold = (state_q == S_HOLD) && !redirect && !stall;
  assign ld_ins  = ld_hold ? hb_ins_q : imem_rdata;

  assign imem_req    = (state_q == S_FETCH);
  assign imem_addr   = fpc_q;
  assign if_id_valid = v_q;
  assign if_id_pc    = pc_q;
  assign if_id_ins   = ins_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_FETCH;
      fpc_q    <= RESET_PC;
      drop_q   <= 1'b0;
      hb_ins_q <= 32'h0;
      v_q      <= 1'b0;
      pc_q     <= 30'h0;
      ins_q    <= 32'h0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (redirect)        fpc_q   <= npc;
          else if (imem_ready) state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if (redirect || drop_q) begin
              drop_q  <= 1'b0;
              state_q <= S_FETCH;
              if (redirect) fpc_q <= npc;
            end else if (!stall) begin
              fpc_q   <= fpc_q + 30'd1;
              state_q <= S_FETCH;
            end else begin
              hb_ins_q <= imem_rdata;
              state_q  <= S_HOLD;
            end
          end else if (redirect) begin
            // Old-address response still in flight; mark it for discard.
            drop_q <= 1'b1;
            fpc_q  <= npc;
          end
        end
        S_HOLD: begin
          if (redirect) begin
            fpc_q   <= npc;
            state_q <= S_FETCH;
          end else if (!stall) begin
            fpc_q   <= fpc_q + 30'd1;
            state_q <= S_FETCH;
          end
        end
        default: state_q <= S_FETCH;
      endcase

      if (redirect) begin
        v_q <= 1'b0;
      end else if (stall) begin
        v_q <= v_q;
      end else if (ld_wait || ld_hold) begin
        v_q   <= 1'b1;
        pc_q  <= fpc_q;
        ins_q <= ld_ins;
      end else begin
        v_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: behavioural imem with programmable latency and a
// scoreboard of expected IF/ID instructions checked as they are loaded.
module tb_ifu_fetch;

  logic        clk, rst;
  logic [29:0] npc;
  logic        redirect, stall;
  logic        imem_req;
  logic [29:0] imem_addr;
  logic        imem_ready, imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_id_valid;
  logic [29:0] if_id_pc;
  logic [31:0] if_id_ins;

  ifu_fetch dut (
    .clk(clk), .rst(rst), .npc(npc), .redirect(redirect), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_id_valid(if_id_valid), .if_id_pc(if_id_pc), .if_id_ins(if_id_ins)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [29:0] pc; logic [31:0] ins; } exp_t;
  exp_t q[$];

  int ntests = 0;
  int nfail  = 0;

  // memory model state
  logic        pend;
  logic [29:0] paddr;
  int          cnt, lat;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    ntests++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [29:0] pc);
    exp_t e;
    e.pc  = pc;
    e.ins = {pc, 2'b00};
    q.push_back(e);
  endtask

  // One clock: memory accepts on req&ready, answers lat cycles later with
  // {addr,2'b00}; any fresh (non-held) IF/ID load is popped from the scoreboard.
  task automatic tick();
    logic        hs, rv, held;
    logic [29:0] a;
    exp_t        e;
    hs   = imem_req & imem_ready & !redirect & !rst;
    rv   = imem_rvalid;
    held = stall | redirect;
    a    = imem_addr;
    @(posedge clk);
    #1;
    if (rst) pend = 1'b0;
    else begin
      if (rv) pend = 1'b0;
      if (hs) begin pend = 1'b1; paddr = a; cnt = lat; end
      else if (pend && cnt > 0) cnt--;
    end
    imem_rvalid = pend && (cnt == 0);
    imem_rdata  = imem_rvalid ? {paddr, 2'b00} : 32'hDEAD_BEEF;
    if (if_id_valid && !held) begin
      if (q.size() == 0) begin
        ntests++;
        nfail++;
        $error("FAIL sb_unexpected: observed pc %h ins %h expected none", if_id_pc, if_id_ins);
      end else begin
        e = q.pop_front();
        chk("sb_pc", 64'(if_id_pc), 64'(e.pc));
        chk("sb_ins", 64'(if_id_ins), 64'(e.ins));
      end
    end
  endtask

  initial begin
    rst = 1'b1; redirect = 1'b0; stall = 1'b0; npc = 30'h0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    pend = 1'b0; paddr = 30'h0; cnt = 0; lat = 0;

    #3;
    chk("rst_req",   64'(imem_req),    64'd1);
    chk("rst_addr",  64'(imem_addr),   64'h0C00);
    chk("rst_valid", 64'(if_id_valid), 64'd0);
    chk("rst_pc",    64'(if_id_pc),    64'd0);
    chk("rst_ins",   64'(if_id_ins),   64'd0);
    @(posedge clk); #1;
    rst = 1'b0; imem_ready = 1'b1;

    // zero-wait streaming: valid alternates 0/1
    push(30'h0C00); push(30'h0C01); push(30'h0C02);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("zw_valid", 64'(if_id_valid), 64'(i % 2));
    end
    chk("zw_addr", 64'(imem_addr), 64'h0C03);

    // stall spanning the response: HOLD, IF/ID frozen, then single load
    stall = 1'b1;
    tick();
    chk("st_hold_v",  64'(if_id_valid), 64'd1);
    chk("st_hold_pc", 64'(if_id_pc),    64'h0C02);
    tick();
    chk("st_req_hold", 64'(imem_req), 64'd0);
    chk("st_hold_pc2", 64'(if_id_pc), 64'h0C02);
    tick();
    chk("st_hold_ins", 64'(if_id_ins), 64'h3008);
    stall = 1'b0;
    push(30'h0C03);
    tick();
    chk("st_rel_v",  64'(if_id_valid), 64'd1);
    chk("st_rel_pc", 64'(if_id_pc),    64'h0C03);
    chk("st_addr",   64'(imem_addr),   64'h0C04);

    // redirect in WAIT two cycles before rvalid
    lat = 2;
    tick();
    redirect = 1'b1; npc = 30'h100;
    tick();
    redirect = 1'b0;
    chk("rw_addr",  64'(imem_addr),   64'h100);
    chk("rw_req",   64'(imem_req),    64'd0);
    chk("rw_valid", 64'(if_id_valid), 64'd0);
    lat = 0;
    tick();
    tick();
    chk("rw_drop_v", 64'(if_id_valid), 64'd0);
    chk("rw_req2",   64'(imem_req),    64'd1);
    chk("rw_addr2",  64'(imem_addr),   64'h100);
    push(30'h100);
    tick(); tick();
    chk("rw_new_pc", 64'(if_id_pc), 64'h100);

    // redirect together with stall while in HOLD
    stall = 1'b1;
    tick(); tick();
    chk("rh_req", 64'(imem_req), 64'd0);
    redirect = 1'b1; npc = 30'h200;
    tick();
    chk("rh_valid", 64'(if_id_valid), 64'd0);
    chk("rh_req2",  64'(imem_req),    64'd1);
    chk("rh_addr",  64'(imem_addr),   64'h200);
    redirect = 1'b0; stall = 1'b0;
    push(30'h200);
    tick(); tick();

    // PC wrap at 30'h3FFF_FFFF
    imem_ready = 1'b0; redirect = 1'b1; npc = 30'h3FFF_FFFF;
    tick();
    redirect = 1'b0; imem_ready = 1'b1;
    chk("wr_addr", 64'(imem_addr), 64'h3FFF_FFFF);
    push(30'h3FFF_FFFF); push(30'h0);
    tick(); tick();
    chk("wr_ins",   64'(if_id_ins), 64'hFFFF_FFFC);
    chk("wr_next",  64'(imem_addr), 64'h0);
    tick(); tick();

    // reset while in WAIT with drop pending, then a stray rvalid
    lat = 3;
    tick();
    redirect = 1'b1; npc = 30'h300;
    tick();
    redirect = 1'b0;
    chk("rr_addr", 64'(imem_addr), 64'h300);
    rst = 1'b1; imem_ready = 1'b0;
    #2;
    chk("rr_req",   64'(imem_req),    64'd1);
    chk("rr_addr0", 64'(imem_addr),   64'h0C00);
    chk("rr_valid", 64'(if_id_valid), 64'd0);
    chk("rr_pc",    64'(if_id_pc),    64'd0);
    chk("rr_ins",   64'(if_id_ins),   64'd0);
    tick();
    rst = 1'b0; lat = 0;
    imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678;
    tick();
    chk("rr_stray_v", 64'(if_id_valid), 64'd0);
    chk("rr_stray_a", 64'(imem_addr),   64'h0C00);
    chk("rr_stray_r", 64'(imem_req),    64'd1);
    imem_ready = 1'b1;
    push(30'h0C00);
    tick(); tick();
    chk("rr_first_v", 64'(if_id_valid), 64'd1);

    chk("sb_drain", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
